// File: rtl/puf_pkg.sv
// puf_pkg: shared constants and loader state encoding for the PUF configuration path
package puf_pkg;
  localparam int INMEM_ADDRESS_WIDTH = 17;
  localparam int WORD_WIDTH = 32;
  localparam int WORDS_PER_BIT = 4;
  localparam int NUM_BITS = 64;
  localparam int CFG_WIDTH = 125;
  localparam int TOTAL_WORDS = NUM_BITS * WORDS_PER_BIT;
  typedef enum logic [1:0] {LD_IDLE, LD_REQ, LD_WAIT, LD_FINISH} ldState_t;
endpackage

// File: rtl/pdl_config_bank.sv
// pdl_config_bank: 64 configuration vectors with per-word writes and a dual core0/core1 read port
module pdl_config_bank
  import puf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [5:0]            wrIndex,
  input  logic [1:0]            wrWord,
  input  logic [WORD_WIDTH-1:0] wrData,
  input  logic [4:0]            bitSel,
  output logic [CFG_WIDTH-1:0]  configCore0,
  output logic [CFG_WIDTH-1:0]  configCore1
);
  // Only the 125 used bits are kept; the top 3 bits of word 3 never reach storage.
  logic [CFG_WIDTH-1:0] vectors [NUM_BITS];
  always_ff @(posedge clk or negedge reset)
    if (!reset) vectors <= '{default: '0};
    else if (wrEn)
      case (wrWord)
        2'd0: vectors[wrIndex][31:0] <= wrData;
        2'd1: vectors[wrIndex][63:32] <= wrData;
        2'd2: vectors[wrIndex][95:64] <= wrData;
        default: vectors[wrIndex][124:96] <= wrData[28:0];
      endcase
  assign configCore0 = vectors[{1'b0, bitSel}];
  assign configCore1 = vectors[{1'b1, bitSel}];
endmodule

// File: rtl/pdl_config_loader.sv
// pdl_config_loader: streams the PDL calibration image from input memory into the config bank
module pdl_config_loader
  import puf_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INMEM_ADDRESS_WIDTH-1:0] baseAdd,
  output logic                           busy,
  output logic                           done,
  output logic                           loaded,
  output logic                           inputMemoryReadReq,
  input  logic                           inputMemoryReadAck,
  output logic [INMEM_ADDRESS_WIDTH-1:0] inputMemoryReadAdd,
  input  logic                           inputMemoryReadDataValid,
  input  logic [WORD_WIDTH-1:0]          inputMemoryReadData,
  input  logic [4:0]                     bitSel,
  output logic [CFG_WIDTH-1:0]           configCore0,
  output logic [CFG_WIDTH-1:0]           configCore1
);
  ldState_t state, nextState;
  logic [7:0] wordCount;
  logic wordStore;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= LD_IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      LD_IDLE: nextState = start ? LD_REQ : LD_IDLE;
      LD_REQ: nextState = inputMemoryReadAck ? LD_WAIT : LD_REQ;
      LD_WAIT: nextState = !inputMemoryReadDataValid ? LD_WAIT :
                           (wordCount == 8'(TOTAL_WORDS - 1)) ? LD_FINISH : LD_REQ;
      default: nextState = LD_IDLE;
    endcase
  end
  always_comb begin
    busy = (state == LD_REQ) || (state == LD_WAIT);
    inputMemoryReadReq = state == LD_REQ;
    done = state == LD_FINISH;
    wordStore = (state == LD_WAIT) && inputMemoryReadDataValid;
  end
  // Address wraps silently at 2^17 through natural overflow.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wordCount <= '0;
      inputMemoryReadAdd <= '0;
      loaded <= 1'b0;
    end else begin
      if (state == LD_IDLE && start) begin
        wordCount <= '0;
        inputMemoryReadAdd <= baseAdd;
        loaded <= 1'b0;
      end else if (wordStore) begin
        wordCount <= wordCount + 8'd1;
        inputMemoryReadAdd <= inputMemoryReadAdd + 1'b1;
      end
      if (state == LD_WAIT && nextState == LD_FINISH) loaded <= 1'b1;
    end
  pdl_config_bank bank (
    .clk(clk),
    .reset(reset),
    .wrEn(wordStore),
    .wrIndex(wordCount[7:2]),
    .wrWord(wordCount[1:0]),
    .wrData(inputMemoryReadData),
    .bitSel(bitSel),
    .configCore0(configCore0),
    .configCore1(configCore1)
  );
endmodule

// File: tb/tb_pdl_config_loader.sv
// tb_pdl_config_loader: directed checks of the config loader against a handshaking memory model
module tb_pdl_config_loader;
  logic clk = 0, reset = 0, start = 0, ack = 0, dv = 0;
  logic [16:0] baseAdd = '0;
  logic [31:0] rdData = '0;
  logic [4:0] bitSel = '0;
  logic busy, done, loaded, req;
  logic [16:0] add;
  logic [124:0] cfg0, cfg1;
  int checks = 0, errors = 0;
  int accepts = 0, overlaps = 0, unstable = 0, donePulses = 0;
  int ackStall = 0, dvDelay = 0, lat = 0, stallCnt = 0;
  bit memMode = 0, spur = 0, pending = 0, prevReq = 0, prevAck = 0, pulsed = 0;
  logic [16:0] prevAdd = '0, pAdd = '0;

  pdl_config_loader dut (
    .clk(clk), .reset(reset), .start(start), .baseAdd(baseAdd),
    .busy(busy), .done(done), .loaded(loaded),
    .inputMemoryReadReq(req), .inputMemoryReadAck(ack), .inputMemoryReadAdd(add),
    .inputMemoryReadDataValid(dv), .inputMemoryReadData(rdData),
    .bitSel(bitSel), .configCore0(cfg0), .configCore1(cfg1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: decides at each negedge what the next posedge sees.
  initial forever begin
    @(negedge clk);
    if (prevReq && prevAck) begin
      if (pending) overlaps++;
      pending = 1;
      lat = dvDelay;
      pAdd = prevAdd;
      accepts++;
    end else if (prevReq && (!req || add != prevAdd)) unstable++;
    dv = 0;
    if (spur) begin
      dv = 1;
      rdData = '1;
      spur = 0;
    end else if (pending) begin
      if (lat == 0) begin
        dv = 1;
        rdData = memMode ? {15'b0, pAdd} : 32'hC0DE0000 + {15'b0, pAdd};
        pending = 0;
      end else lat--;
    end
    ack = 0;
    if (req) begin
      if (stallCnt >= ackStall) begin
        ack = 1;
        stallCnt = 0;
      end else stallCnt++;
    end else stallCnt = 0;
    prevReq = req;
    prevAck = ack;
    prevAdd = add;
  end

  initial forever begin
    @(negedge clk);
    if (done) donePulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic startLoad(input logic [16:0] b);
    @(negedge clk);
    baseAdd = b;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic waitDone(input int budget);
    for (int n = 0; n < budget && !done; n++) @(negedge clk);
    check("doneSeen", done, 1);
  endtask

  initial begin
    @(negedge clk);
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    check("rstLoaded", loaded, 0);
    check("rstReq", req, 0);
    check("rstAdd", add, 0);
    check("rstCfg0", cfg0, 0);
    check("rstCfg1", cfg1, 0);
    reset = 1;
    spur = 1;
    repeat (3) @(negedge clk);
    check("spurCfg0", cfg0, 0);
    check("spurCfg1", cfg1, 0);
    check("spurBusy", busy, 0);

    accepts = 0; donePulses = 0;
    startLoad(17'h0);
    check("startBusy", busy, 1);
    check("startReq", req, 1);
    check("startAdd", add, 0);
    check("startLoaded", loaded, 0);
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (accepts == 50 && !pulsed) begin
        start = 1;
        baseAdd = 17'h100;
        pulsed = 1;
      end else start = 0;
    end
    check("doneSeenA", done, 1);
    check("finLoaded", loaded, 1);
    check("finBusy", busy, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    check("finStartBusy", busy, 0);
    check("finStartReq", req, 0);
    repeat (3) @(negedge clk);
    check("aDonePulses", donePulses, 1);
    check("aAccepts", accepts, 256);
    check("aOverlaps", overlaps, 0);
    bitSel = 0; #1;
    check("aC0w0", cfg0[31:0], 32'hC0DE0000);
    check("aC0w3", cfg0[124:96], 29'h00DE0003);
    check("aC1w0", cfg1[31:0], 32'hC0DE0080);
    bitSel = 5; #1;
    check("aC0b5w1", cfg0[63:32], 32'hC0DE0015);
    bitSel = 31; #1;
    check("aC1b31w2", cfg1[95:64], 32'hC0DE00FE);

    memMode = 1; ackStall = 5; dvDelay = 3;
    accepts = 0; donePulses = 0; unstable = 0; overlaps = 0;
    startLoad(17'h1FFF0);
    waitDone(6000);
    repeat (2) @(negedge clk);
    check("bAccepts", accepts, 256);
    check("bOverlaps", overlaps, 0);
    check("bStable", unstable, 0);
    check("bDonePulses", donePulses, 1);
    check("bEndAdd", add, 17'h000F0);
    bitSel = 0; #1;
    check("bC0b0w0", cfg0[31:0], 32'h0001FFF0);
    check("bC1b0w0", cfg1[31:0], 32'h00000070);
    bitSel = 3; #1;
    check("bC0b3w3", cfg0[124:96], 29'h0001FFFF);
    bitSel = 4; #1;
    check("bWrapW0", cfg0[31:0], 32'h0);
    check("bWrapW1", cfg0[63:32], 32'h1);

    memMode = 0; ackStall = 0; dvDelay = 3; accepts = 0;
    startLoad(17'h0);
    for (int n = 0; n < 3000 && accepts < 101; n++) @(negedge clk);
    #2 reset = 0;
    prevReq = 0; prevAck = 0; ack = 0;
    bitSel = 0; #1;
    check("rmBusy", busy, 0);
    check("rmReq", req, 0);
    check("rmAdd", add, 0);
    check("rmLoaded", loaded, 0);
    check("rmDone", done, 0);
    check("rmCfg0", cfg0, 0);
    check("rmCfg1", cfg1, 0);
    @(negedge clk);
    #2 reset = 1;
    repeat (6) @(negedge clk);
    check("lateDvCfg0", cfg0, 0);
    check("lateDvBusy", busy, 0);

    dvDelay = 0; accepts = 0; donePulses = 0; overlaps = 0;
    startLoad(17'h0);
    check("reLoadedLow", loaded, 0);
    waitDone(3000);
    check("reLoaded", loaded, 1);
    repeat (2) @(negedge clk);
    check("reAccepts", accepts, 256);
    check("reDonePulses", donePulses, 1);
    bitSel = 0; #1;
    check("reC0w0", cfg0[31:0], 32'hC0DE0000);
    bitSel = 31; #1;
    check("reC1b31w0", cfg1[31:0], 32'hC0DE00FC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
